// File: rtl/eth_gen_pkg.sv
// Shared definitions for the Ethernet test-frame generator.
//   - FSM state encoding
//   - byte offsets of the header fields inside a frame
//   - payload modes
//   - PRBS LFSR seed, tap mask and step function
package eth_gen_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FRAME = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam int OFS_DST  = 0;
    localparam int OFS_SRC  = 6;
    localparam int OFS_TYPE = 12;
    localparam int OFS_SEQ  = 14;
    localparam int OFS_PAY  = 18;

    localparam logic [1:0] MODE_ZERO = 2'd0;
    localparam logic [1:0] MODE_INC  = 2'd1;
    localparam logic [1:0] MODE_PRBS = 2'd2;

    // Fibonacci LFSR x^8+x^6+x^5+x^4+1: stages 8,6,5,4 are bits 7,5,4,3
    // of a left-shifting register.
    localparam logic [7:0] LFSR_SEED = 8'hFF;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/eth_payload_gen.sv
// Payload byte source for eth_frame_gen.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   mode         0 zero, 1 incrementing counter, 2 PRBS, 3 as zero
//   advance      a payload byte was accepted; step to the next one
//   restart      new frame; counter to 0, LFSR to seed (wins over advance)
//   pay_byte     current payload byte
module eth_payload_gen
    import eth_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    input  logic       advance,
    input  logic       restart,
    output logic [7:0] pay_byte
);

    logic [7:0] lfsr_q, lfsr_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        lfsr_d = lfsr_q;
        cnt_d  = cnt_q;
        if (restart) begin
            lfsr_d = LFSR_SEED;
            cnt_d  = 8'h00;
        end else if (advance) begin
            lfsr_d = lfsr_next(lfsr_q);
            cnt_d  = cnt_q + 8'h01;
        end
    end

    always_comb begin
        case (mode)
            MODE_INC:  pay_byte = cnt_q;
            MODE_PRBS: pay_byte = lfsr_q;
            default:   pay_byte = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
            cnt_q  <= 8'h00;
        end else begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/eth_frame_gen.sv
// Ethernet test-frame generator (no FCS). Emits runs of frames as a byte
// stream: dst MAC, src MAC, ethertype, 32-bit sequence, then payload.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, stop               run control pulses
//   cfg_len/gap/count/mode    frame length, idle gap, frames per run, payload
//   cfg_dst_mac/src_mac/ethertype   header fields
//   tx_valid/data/last/ready  byte stream to the MAC
//   busy, done, frames_sent   run status
module eth_frame_gen
    import eth_gen_pkg::*;
#(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514,
    parameter int LEN_W   = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [15:0]      cfg_gap,
    input  logic [15:0]      cfg_count,
    input  logic [1:0]       cfg_mode,
    input  logic [47:0]      cfg_dst_mac,
    input  logic [47:0]      cfg_src_mac,
    input  logic [15:0]      cfg_ethertype,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    output logic             tx_last,
    input  logic             tx_ready,
    output logic             busy,
    output logic             done,
    output logic [31:0]      frames_sent
);

    logic [1:0]       state_q, state_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [31:0]      frames_q, frames_d;
    logic [15:0]      gap_cnt_q, gap_cnt_d;
    logic             stop_seen_q, stop_seen_d;
    logic             done_q, done_d;

    logic [LEN_W-1:0] len_q, len_d, len_clamped;
    logic [15:0]      gap_q, gap_d, count_q, count_d;
    logic [1:0]       mode_q, mode_d;
    logic [47:0]      dst_q, dst_d, src_q, src_d;
    logic [15:0]      type_q, type_d;

    logic             latch;
    logic             xfer;
    logic             at_last;
    logic [7:0]       pay_byte, hdr_byte;
    logic [2:0]       rel_mac;
    logic [1:0]       rel_seq;
    logic             rel_type;

    function automatic logic [7:0] pick_mac(input logic [47:0] f, input logic [2:0] i);
        case (i)
            3'd0:    return f[47:40];
            3'd1:    return f[39:32];
            3'd2:    return f[31:24];
            3'd3:    return f[23:16];
            3'd4:    return f[15:8];
            3'd5:    return f[7:0];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] pick_seq(input logic [31:0] f, input logic [1:0] i);
        case (i)
            2'd0:    return f[31:24];
            2'd1:    return f[23:16];
            2'd2:    return f[15:8];
            default: return f[7:0];
        endcase
    endfunction

    assign tx_valid    = (state_q == ST_FRAME);
    assign at_last     = (idx_q == len_q - LEN_W'(1));
    assign tx_last     = tx_valid && at_last;
    assign xfer        = tx_valid && tx_ready;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign frames_sent = frames_q;

    always_comb begin
        if (cfg_len < LEN_W'(MIN_LEN))      len_clamped = LEN_W'(MIN_LEN);
        else if (cfg_len > LEN_W'(MAX_LEN)) len_clamped = LEN_W'(MAX_LEN);
        else                                len_clamped = cfg_len;
    end

    // Run/frame sequencing. latch marks every entry into FRAME.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frames_d    = frames_q;
        gap_cnt_d   = gap_cnt_q;
        stop_seen_d = stop_seen_q;
        done_d      = 1'b0;
        latch       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d     = ST_FRAME;
                    idx_d       = '0;
                    frames_d    = '0;
                    stop_seen_d = 1'b0;
                    latch       = 1'b1;
                end
            end
            ST_FRAME: begin
                if (stop) stop_seen_d = 1'b1;
                if (xfer) begin
                    if (at_last) begin
                        frames_d = frames_q + 32'd1;
                        if (stop_seen_q || stop ||
                            (count_q != 16'd0 && frames_d == {16'd0, count_q})) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else if (gap_q != 16'd0) begin
                            state_d   = ST_GAP;
                            gap_cnt_d = gap_q;
                        end else begin
                            idx_d = '0;
                            latch = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else if (gap_cnt_q == 16'd1) begin
                    state_d = ST_FRAME;
                    idx_d   = '0;
                    latch   = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        len_d   = len_q;
        gap_d   = gap_q;
        count_d = count_q;
        mode_d  = mode_q;
        dst_d   = dst_q;
        src_d   = src_q;
        type_d  = type_q;
        if (latch) begin
            len_d   = len_clamped;
            gap_d   = cfg_gap;
            count_d = cfg_count;
            mode_d  = cfg_mode;
            dst_d   = cfg_dst_mac;
            src_d   = cfg_src_mac;
            type_d  = cfg_ethertype;
        end
    end

    // Byte mux over the header fields; payload beyond OFS_PAY.
    always_comb begin
        rel_mac  = 3'(idx_q - LEN_W'(OFS_DST));
        rel_type = 1'(idx_q - LEN_W'(OFS_TYPE));
        rel_seq  = 2'(idx_q - LEN_W'(OFS_SEQ));
        if (idx_q < LEN_W'(OFS_SRC)) begin
            hdr_byte = pick_mac(dst_q, rel_mac);
        end else if (idx_q < LEN_W'(OFS_TYPE)) begin
            rel_mac  = 3'(idx_q - LEN_W'(OFS_SRC));
            hdr_byte = pick_mac(src_q, rel_mac);
        end else if (idx_q < LEN_W'(OFS_SEQ)) begin
            hdr_byte = rel_type ? type_q[7:0] : type_q[15:8];
        end else if (idx_q < LEN_W'(OFS_PAY)) begin
            hdr_byte = pick_seq(frames_q, rel_seq);
        end else begin
            hdr_byte = pay_byte;
        end
    end

    assign tx_data = tx_valid ? hdr_byte : 8'h00;

    eth_payload_gen u_payload (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode_q),
        .advance  (xfer && (idx_q >= LEN_W'(OFS_PAY))),
        .restart  (latch),
        .pay_byte (pay_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            frames_q    <= '0;
            gap_cnt_q   <= '0;
            stop_seen_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frames_q    <= frames_d;
            gap_cnt_q   <= gap_cnt_d;
            stop_seen_q <= stop_seen_d;
            done_q      <= done_d;
        end
    end

    // Frame configuration snapshot; only meaningful while busy.
    always_ff @(posedge clk) begin
        len_q   <= len_d;
        gap_q   <= gap_d;
        count_q <= count_d;
        mode_q  <= mode_d;
        dst_q   <= dst_d;
        src_q   <= src_d;
        type_q  <= type_d;
    end

endmodule

// File: tb/tb_eth_frame_gen.sv
// Scoreboard bench for eth_frame_gen: expected frame bytes are queued when a
// run is launched and popped on every accepted byte.
module tb_eth_frame_gen;

    localparam int MIN_LEN = 60;
    localparam int MAX_LEN = 1514;
    localparam int LEN_W   = 11;

    localparam logic [47:0] DST  = 48'hA1B2C3D4E5F6;
    localparam logic [47:0] SRC  = 48'h112233445566;
    localparam logic [15:0] ETYP = 16'h88B5;

    logic             clk;
    logic             rst;
    logic             start;
    logic             stop;
    logic [LEN_W-1:0] cfg_len;
    logic [15:0]      cfg_gap;
    logic [15:0]      cfg_count;
    logic [1:0]       cfg_mode;
    logic [47:0]      cfg_dst_mac;
    logic [47:0]      cfg_src_mac;
    logic [15:0]      cfg_ethertype;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_last;
    logic             tx_ready;
    logic             busy;
    logic             done;
    logic [31:0]      frames_sent;

    eth_frame_gen #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .stop          (stop),
        .cfg_len       (cfg_len),
        .cfg_gap       (cfg_gap),
        .cfg_count     (cfg_count),
        .cfg_mode      (cfg_mode),
        .cfg_dst_mac   (cfg_dst_mac),
        .cfg_src_mac   (cfg_src_mac),
        .cfg_ethertype (cfg_ethertype),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_last       (tx_last),
        .tx_ready      (tx_ready),
        .busy          (busy),
        .done          (done),
        .frames_sent   (frames_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboard and monitor state
    logic [8:0] exp_q[$];   // {last, data}
    int         gaps_q[$];
    int         lens_q[$];
    int         done_cnt = 0;
    int         byte_cnt = 0;
    int         idle_run = 0;
    bit         after_last = 0;
    bit         in_frame = 0;
    bit         prev_stall = 0;
    logic [7:0] prev_data;
    logic       prev_last;
    logic [8:0] mon_e;
    bit         stall_en = 0;

    function automatic logic [7:0] prbs_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic int clamp_len(input int l);
        if (l < MIN_LEN) return MIN_LEN;
        if (l > MAX_LEN) return MAX_LEN;
        return l;
    endfunction

    task automatic push_frame(input int len_cfg, input logic [1:0] mode, input logic [31:0] seq);
        int         L;
        logic [7:0] b;
        logic [7:0] lf;
        logic [47:0] d, s;
        logic [15:0] t;
        L  = clamp_len(len_cfg);
        lf = 8'hFF;
        d  = DST;
        s  = SRC;
        t  = ETYP;
        for (int i = 0; i < L; i++) begin
            if (i < 6)       b = d[8*(5-i) +: 8];
            else if (i < 12) b = s[8*(11-i) +: 8];
            else if (i < 14) b = t[8*(13-i) +: 8];
            else if (i < 18) b = seq[8*(17-i) +: 8];
            else begin
                case (mode)
                    2'd1: b = 8'(i - 18);
                    2'd2: begin b = lf; lf = prbs_step(lf); end
                    default: b = 8'h00;
                endcase
            end
            exp_q.push_back({(i == L - 1), b});
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            byte_cnt   = 0;
            in_frame   = 0;
            after_last = 0;
            prev_stall = 0;
        end else begin
            if (done) done_cnt++;
            if (prev_stall) begin
                check("stall_valid", 32'(tx_valid), 32'd1);
                check("stall_data", 32'(tx_data), 32'(prev_data));
                check("stall_last", 32'(tx_last), 32'(prev_last));
            end
            if (in_frame) check("no_bubble", 32'(tx_valid), 32'd1);
            if (after_last) begin
                if (!busy) after_last = 0;
                else if (tx_valid) begin
                    gaps_q.push_back(idle_run);
                    after_last = 0;
                end else idle_run++;
            end
            if (tx_valid && tx_ready) begin
                check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    mon_e = exp_q.pop_front();
                    check("tx_data", 32'(tx_data), 32'(mon_e[7:0]));
                    check("tx_last", 32'(tx_last), 32'(mon_e[8]));
                end
                byte_cnt++;
                if (tx_last) begin
                    lens_q.push_back(byte_cnt);
                    byte_cnt   = 0;
                    in_frame   = 0;
                    after_last = 1;
                    idle_run   = 0;
                end else in_frame = 1;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_last  = tx_last;
        end
    end

    initial begin
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(posedge clk); #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, input string tag);
        int n = 0;
        while (done_cnt == base && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(done_cnt != base), 32'd1);
    endtask

    task automatic wait_bytes(input int nframes, input int nbytes, input string tag);
        int n = 0;
        while (!(lens_q.size() >= nframes && byte_cnt >= nbytes) && n < 5000) begin
            tick();
            n++;
        end
        check(tag, 32'(lens_q.size() >= nframes && byte_cnt >= nbytes), 32'd1);
    endtask

    task automatic set_cfg(input int len_cfg, input logic [1:0] mode, input int count, input int gap);
        cfg_len   = LEN_W'(len_cfg);
        cfg_mode  = mode;
        cfg_count = 16'(count);
        cfg_gap   = 16'(gap);
    endtask

    task automatic run_test(input string tag, input int len_cfg, input logic [1:0] mode,
                            input int count, input int gap, input bit stalls);
        int base_done, base_lens, base_gaps;
        set_cfg(len_cfg, mode, count, gap);
        stall_en = stalls;
        for (int f = 0; f < count; f++) push_frame(len_cfg, mode, 32'(f));
        base_done = done_cnt;
        base_lens = lens_q.size();
        base_gaps = gaps_q.size();
        pulse_start();
        wait_done(base_done, 30000, {tag, "_done_timeout"});
        stall_en = 0;
        repeat (3) tick();
        check({tag, "_done_pulses"}, 32'(done_cnt - base_done), 32'd1);
        check({tag, "_frames_sent"}, frames_sent, 32'(count));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_nframes"}, 32'(lens_q.size() - base_lens), 32'(count));
        for (int i = base_lens; i < lens_q.size(); i++)
            check({tag, "_len"}, 32'(lens_q[i]), 32'(clamp_len(len_cfg)));
        check({tag, "_ngaps"}, 32'(gaps_q.size() - base_gaps), 32'(count - 1));
        for (int i = base_gaps; i < gaps_q.size(); i++)
            check({tag, "_gap"}, 32'(gaps_q[i]), 32'(gap));
    endtask

    initial begin
        int base_done, base_lens, base_gaps;
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        cfg_dst_mac = DST; cfg_src_mac = SRC; cfg_ethertype = ETYP;
        set_cfg(64, 2'd0, 1, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_last", 32'(tx_last), 32'd0);
        check("rst_data", 32'(tx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_frames", frames_sent, 32'd0);

        // start and stop together in IDLE, then stop alone in IDLE
        @(posedge clk); #1 start = 1'b1; stop = 1'b1;
        @(posedge clk); #1 start = 1'b0; stop = 1'b0;
        pulse_stop();
        repeat (3) tick();
        check("startstop_busy", 32'(busy), 32'd0);
        check("startstop_done", 32'(done_cnt), 32'd0);

        run_test("inc64", 64, 2'd1, 1, 0, 0);
        run_test("short", 20, 2'd0, 1, 0, 0);
        run_test("long", 2000, 2'd1, 1, 0, 0);
        run_test("prbs", 80, 2'd2, 2, 3, 1);
        run_test("gap12", 64, 2'd0, 3, 12, 0);
        run_test("mode3", 60, 2'd3, 1, 0, 0);

        // continuous back-to-back run, start ignored while busy, stop in frame 2
        set_cfg(64, 2'd1, 0, 0);
        push_frame(64, 2'd1, 32'd0);
        push_frame(64, 2'd1, 32'd1);
        base_done = done_cnt; base_lens = lens_q.size(); base_gaps = gaps_q.size();
        pulse_start();
        wait_bytes(base_lens, 10, "b2b_wait_b10");
        pulse_start();
        wait_bytes(base_lens + 1, 30, "b2b_wait_f2");
        pulse_stop();
        wait_done(base_done, 200, "b2b_done_timeout");
        repeat (3) tick();
        check("b2b_frames_sent", frames_sent, 32'd2);
        check("b2b_nframes", 32'(lens_q.size() - base_lens), 32'd2);
        check("b2b_ngaps", 32'(gaps_q.size() - base_gaps), 32'd1);
        if (gaps_q.size() > base_gaps) check("b2b_gap", 32'(gaps_q[base_gaps]), 32'd0);
        check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);
        check("b2b_busy", 32'(busy), 32'd0);
        check("b2b_done_pulses", 32'(done_cnt - base_done), 32'd1);

        // stop during GAP ends the run at once
        set_cfg(60, 2'd0, 0, 20);
        push_frame(60, 2'd0, 32'd0);
        base_done = done_cnt; base_lens = lens_q.size();
        pulse_start();
        wait_bytes(base_lens + 1, 0, "gapstop_wait");
        pulse_stop();
        wait_done(base_done, 4, "gapstop_done_timeout");
        repeat (2) tick();
        check("gapstop_frames_sent", frames_sent, 32'd1);
        check("gapstop_busy", 32'(busy), 32'd0);
        check("gapstop_sb_empty", 32'(exp_q.size()), 32'd0);

        // reset in the middle of a frame
        set_cfg(64, 2'd0, 1, 0);
        push_frame(64, 2'd0, 32'd0);
        base_lens = lens_q.size();
        pulse_start();
        wait_bytes(base_lens, 30, "rstmid_wait");
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check("rstmid_valid", 32'(tx_valid), 32'd0);
        check("rstmid_last", 32'(tx_last), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_frames", frames_sent, 32'd0);
        rst = 1'b0;
        exp_q.delete();
        tick();
        check("rstmid_no_last", 32'(lens_q.size()), 32'(base_lens));
        run_test("after_rst", 64, 2'd1, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

endmodule

// File: doc/eth_frame_gen.md
ETH_FRAME_GEN -- requirements
Module: eth_frame_gen

Interface
REQ-001 SHALL have parameter MIN_LEN, default 60, minimum frame length in bytes excluding FCS.
REQ-002 SHALL have parameter MAX_LEN, default 1514, maximum frame length in bytes excluding FCS.
REQ-003 SHALL have parameter LEN_W, default 11, width of length fields.
REQ-004 SHALL have ports: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-005 SHALL have ports: start  in  1  pulse, begin a run; stop  in  1  pulse, end run after current frame.
REQ-006 SHALL have ports: cfg_len  in  LEN_W  frame length; cfg_gap  in  16  idle cycles between frames; cfg_count  in  16  frames per run, 0 = continuous.
REQ-007 SHALL have ports: cfg_mode  in  2  payload mode, 0 zero, 1 increment, 2 PRBS, 3 reserved (treated as 0).
REQ-008 SHALL have ports: cfg_dst_mac  in  48; cfg_src_mac  in  48; cfg_ethertype  in  16.
REQ-009 SHALL have ports: tx_valid  out  1; tx_data  out  8; tx_last  out  1; tx_ready  in  1  byte stream to the MAC TX interface.
REQ-010 SHALL have ports: busy  out  1  run active; done  out  1  one-cycle pulse at run end; frames_sent  out  32  frames completed since last start.

Function
REQ-011 SHALL implement states IDLE, FRAME, GAP; reset state IDLE.
REQ-012 IDLE->FRAME on start; start while busy SHALL be ignored.
REQ-013 On entering FRAME SHALL latch all cfg_* inputs, clamping length to [MIN_LEN, MAX_LEN]; cfg changes mid-frame SHALL have no effect.
REQ-014 Frame byte order SHALL be: bytes 0-5 cfg_dst_mac MSB first, 6-11 cfg_src_mac MSB first, 12-13 cfg_ethertype MSB first, 14-17 32-bit sequence number big-endian, 18..len-1 payload.
REQ-015 Sequence number SHALL be 0 for the first frame of a run, incrementing by 1 per frame, wrapping at 2^32.
REQ-016 Payload mode 1 SHALL emit byte k of payload (k=0 at frame byte 18) as k[7:0], wrapping 255->0.
REQ-017 Payload mode 2 SHALL emit an 8-bit Fibonacci LFSR x^8+x^6+x^5+x^4+1, seeded 0xFF at every frame start, emitting current state then advancing once per accepted byte.
REQ-018 A byte SHALL transfer on a cycle with tx_valid && tx_ready; tx_data and tx_last SHALL stay stable while tx_valid && !tx_ready.
REQ-019 tx_valid SHALL be high for every byte of a frame with no bubbles, independent of tx_ready.
REQ-020 tx_last SHALL be high only on byte len-1.
REQ-021 After last byte transfer, frames_sent SHALL increment, then go to GAP when cfg_gap>0, else straight to next FRAME (back-to-back, first byte valid the following cycle).
REQ-022 GAP SHALL hold tx_valid low for exactly cfg_gap cycles.
REQ-023 Run SHALL end (->IDLE, done pulse) when frames_sent of the run reaches cfg_count (nonzero), or after the current frame when stop was seen.
REQ-024 stop in IDLE SHALL be ignored; stop in GAP SHALL end the run immediately with done.
REQ-025 start and stop in the same cycle in IDLE SHALL start no run.
REQ-026 busy SHALL be high in FRAME and GAP.
REQ-027 frames_sent SHALL clear on accepted start and wrap at 2^32.

Reset
REQ-028 rst SHALL, on the clock edge, force IDLE, tx_valid=0, tx_last=0, tx_data=0, busy=0, done=0, frames_sent=0, sequence=0, LFSR=0xFF.
REQ-029 rst mid-frame SHALL abort the frame without asserting tx_last; next run SHALL start at sequence 0.

Structure
REQ-030 State encoding, header offsets (0, 6, 12, 14, 18) and LFSR polynomial/seed SHALL live in shared package eth_gen_pkg.
REQ-031 Payload generation SHALL be a sub-module eth_payload_gen (mode, advance, restart -> byte).

Verification
REQ-032 cfg_len=64, mode=1, count=1, tx_ready=1 -> 64 consecutive valid bytes, byte 18=0x00, byte 63=0x2D with tx_last, frames_sent=1, one done pulse.
REQ-033 cfg_len=20 and cfg_len=2000 -> frames of 60 and 1514 bytes respectively.
REQ-034 mode=2, random tx_ready stalls -> payload starts 0xFF, each byte equals LFSR successor of previous, no data change during stall.
REQ-035 count=3, gap=12 -> sequence fields 0,1,2; exactly 12 idle cycles between frames; done after third frame.
REQ-036 count=0, gap=0, stop mid-frame 2 -> back-to-back frames, run ends after frame 2 tx_last, frames_sent=2.
REQ-037 rst at byte 30 of a frame -> tx_valid low next cycle, no tx_last; new start emits sequence 0.
